sap1_datapath: RTL and testbench
================================

SAP1_DATAPATH -- requirements
Module: sap1_datapath

Interface
REQ-001 SHALL have parameter RAM_INIT_ZERO, default 1, meaning RAM cleared to 0x00 at elaboration (simulation only).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ctrl  input  12  control word: [11] HLT, [10] PC_INC, [9] PC_EN, [8] MEM_LOAD, [7] MEM_EN, [6] IR_LOAD, [5] IR_EN, [4] A_LOAD, [3] A_EN, [2] B_LOAD, [1] ADDER_SUB, [0] ADDER_EN.
REQ-005 SHALL have port prog_we  input  1  RAM program-write strobe.
REQ-006 SHALL have port prog_addr  input  4  RAM program-write address.
REQ-007 SHALL have port prog_data  input  8  RAM program-write data.
REQ-008 SHALL have port opcode  output  4  current instruction opcode, = ir[7:4], combinational.
REQ-009 SHALL have port bus  output  8  internal bus value, combinational.
REQ-010 SHALL have port a_out  output  8  accumulator A.
REQ-011 SHALL have port carry  output  1  carry/no-borrow flag from last adder result loaded into A.
REQ-012 SHALL have port halted  output  1  sticky halt flag.
REQ-013 SHALL have port bus_err  output  1  sticky multi-driver flag.

Function
REQ-014 SHALL hold registers pc[3:0], mar[3:0], ir[7:0], a[7:0], b[7:0], carry, halted, bus_err, plus a 16x8 RAM.
REQ-015 SHALL drive bus from the single enabled source: PC_EN -> {4'h0,pc}; MEM_EN -> ram[mar]; IR_EN -> {4'h0,ir[3:0]}; A_EN -> a; ADDER_EN -> adder result; none -> 8'h00.
REQ-016 SHALL, when more than one enable is high, resolve by fixed priority ADDER_EN > A_EN > IR_EN > MEM_EN > PC_EN.
REQ-017 SHALL set bus_err at the clock edge where more than one enable is high and halted=0; bus_err cleared only by reset.
REQ-018 SHALL compute adder result combinationally: ADDER_SUB=0 -> a+b; ADDER_SUB=1 -> a+~b+1; 8-bit wrap; carry-out is bit 8 of that 9-bit sum.
REQ-019 SHALL on each rising edge with halted=0 apply all asserted loads in parallel from the pre-edge bus: MEM_LOAD mar<=bus[3:0]; IR_LOAD ir<=bus; A_LOAD a<=bus; B_LOAD b<=bus.
REQ-020 SHALL update carry only on edges where A_LOAD and ADDER_EN are both high, capturing the adder carry-out; otherwise hold.
REQ-021 SHALL increment pc on PC_INC, wrapping 4'hF -> 4'h0; PC_INC with PC_EN in the same cycle drives the old pc onto bus and pc becomes pc+1 after the edge.
REQ-022 SHALL set halted on the edge where HLT=1; halted stays set until reset.
REQ-023 SHALL, while halted=1, freeze pc, mar, ir, a, b, carry and bus_err; bus remains combinational.
REQ-024 SHALL write ram[prog_addr]<=prog_data on any edge with prog_we=1, halted or not; there is no ctrl-driven RAM write path.
REQ-025 SHALL, when prog_we targets ram[mar] while MEM_EN is high, drive old data on bus that cycle; new data is visible from the next cycle.
REQ-026 SHALL reach the A/B/IR/MAR flops through one edge: ctrl asserted in cycle N has its effect visible on outputs in cycle N+1.

Reset
REQ-027 SHALL on rst_n=0 immediately clear pc, mar, ir, a, b, carry, halted and bus_err to 0, independent of clk.
REQ-028 SHALL leave RAM contents unchanged on reset.
REQ-029 SHALL, with rst_n=0 and ctrl=0, give outputs opcode=0, bus=0x00, a_out=0x00, carry=0, halted=0, bus_err=0.
REQ-030 SHALL ignore ctrl and prog_we while rst_n=0; the first effective edge is the first rising clk after rst_n deasserts.

Verification
REQ-031 SHALL pass: RAM = {0x09,0x1A,0x2B,0xF0,...,[9]=0x1C,[A]=0x0E,[B]=0x05}, drive the 6-stage fetch/execute ctrl sequence -> a_out 0x1C, 0x2A, 0x25, then halted=1 with pc=4.
REQ-032 SHALL pass: a=0xF0, b=0x20, ADDER_EN+A_LOAD -> a_out=0x10, carry=1; a=0x05, b=0x07, SUB -> a_out=0xFE, carry=0.
REQ-033 SHALL pass: pc=0xF, PC_INC -> pc=0x0; PC_EN+PC_INC same cycle -> bus=0x0F that cycle, next PC_EN shows 0x00.
REQ-034 SHALL pass: A_EN and MEM_EN together with a=0x33, ram[mar]=0x44 -> bus=0x33, bus_err=1 after edge, remains 1 until rst_n low.
REQ-035 SHALL pass: HLT asserted, then A_LOAD/PC_INC pulses -> a_out and pc unchanged; prog_we still writes RAM.
REQ-036 SHALL pass: rst_n pulsed low mid-instruction (between clk edges) -> all registers 0 immediately, RAM contents retained.

Source files
------------

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, IR, A, B, adder/subtractor, 16x8 RAM and a
// single 8-bit bus.  A sequencer outside this block drives the 12-bit
// control word each cycle.  Every asserted load captures the bus value
// present before the rising edge.  HLT freezes the architectural
// registers until reset.  The program port keeps writing RAM while the
// datapath is halted.
//
// Handshake: there is no valid/ready pairing here.  The control word is
// sampled on every rising edge, and its effect is visible on the outputs
// in the following cycle.  prog_we is a plain write strobe with no
// backpressure.
module sap1_datapath #(
   parameter int RAM_INIT_ZERO = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] ctrl,
   input  logic        prog_we,
   input  logic [3:0]  prog_addr,
   input  logic [7:0]  prog_data,
   output logic [3:0]  opcode,
   output logic [7:0]  bus,
   output logic [7:0]  a_out,
   output logic        carry,
   output logic        halted,
   output logic        bus_err
);

   // Control word bit positions
   localparam int C_HLT      = 11;
   localparam int C_PC_INC   = 10;
   localparam int C_PC_EN    = 9;
   localparam int C_MEM_LOAD = 8;
   localparam int C_MEM_EN   = 7;
   localparam int C_IR_LOAD  = 6;
   localparam int C_IR_EN    = 5;
   localparam int C_A_LOAD   = 4;
   localparam int C_A_EN     = 3;
   localparam int C_B_LOAD   = 2;
   localparam int C_ADD_SUB  = 1;
   localparam int C_ADD_EN   = 0;

   localparam logic [7:0] RAM_RESET_VAL = (RAM_INIT_ZERO != 0) ? 8'h00 : 8'hxx;

   logic [3:0] r_pc;
   logic [3:0] r_mar;
   logic [7:0] r_ir;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic       r_carry;
   logic       r_halted;
   logic       r_bus_err;

   // The RAM has no reset.  Its start-up contents apply only to simulation.
   logic [7:0] r_ram [0:15] = '{default: RAM_RESET_VAL};

   logic [7:0] w_b_operand;
   logic [8:0] w_sum;
   logic [7:0] w_bus;
   logic [2:0] w_en_count;
   logic       w_multi_en;

   // Adder/subtractor.  When subtracting, B is inverted and the carry-in is
   // set, so bit 8 of the sum means "no borrow".
   assign w_b_operand = ctrl[C_ADD_SUB] ? ~r_b : r_b;
   assign w_sum       = {1'b0, r_a} + {1'b0, w_b_operand} + {8'h00, ctrl[C_ADD_SUB]};

   // Count the bus drivers.  More than one driver is a sequencer bug, and it
   // is recorded in the sticky bus_err flag.
   assign w_en_count = {2'b00, ctrl[C_PC_EN]} + {2'b00, ctrl[C_MEM_EN]} +
                       {2'b00, ctrl[C_IR_EN]} + {2'b00, ctrl[C_A_EN]} +
                       {2'b00, ctrl[C_ADD_EN]};
   assign w_multi_en = (w_en_count > 3'd1);

   // Bus mux.  Contention resolves deterministically, with the adder having
   // the highest priority and the PC the lowest.
   always_comb begin
      w_bus = 8'h00;
      if (ctrl[C_ADD_EN])
         w_bus = w_sum[7:0];
      else if (ctrl[C_A_EN])
         w_bus = r_a;
      else if (ctrl[C_IR_EN])
         w_bus = {4'h0, r_ir[3:0]};
      else if (ctrl[C_MEM_EN])
         w_bus = r_ram[r_mar];
      else if (ctrl[C_PC_EN])
         w_bus = {4'h0, r_pc};
   end

   // Architectural registers.  The registers are frozen once halted.  Every
   // asserted load captures the bus value from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= 4'h0;
         r_mar     <= 4'h0;
         r_ir      <= 8'h00;
         r_a       <= 8'h00;
         r_b       <= 8'h00;
         r_carry   <= 1'b0;
         r_halted  <= 1'b0;
         r_bus_err <= 1'b0;
      end else if (!r_halted) begin
         if (ctrl[C_MEM_LOAD]) r_mar <= w_bus[3:0];
         if (ctrl[C_IR_LOAD])  r_ir  <= w_bus;
         if (ctrl[C_A_LOAD])   r_a   <= w_bus;
         if (ctrl[C_B_LOAD])   r_b   <= w_bus;
         if (ctrl[C_PC_INC])   r_pc  <= r_pc + 4'h1;
         if (ctrl[C_A_LOAD] && ctrl[C_ADD_EN])
            r_carry <= w_sum[8];
         if (ctrl[C_HLT])      r_halted  <= 1'b1;
         if (w_multi_en)       r_bus_err <= 1'b1;
      end
   end

   // Program-load port.  It is independent of halt, and it is blocked
   // while reset is held.
   always_ff @(posedge clk) begin
      if (prog_we && rst_n)
         r_ram[prog_addr] <= prog_data;
   end

   assign opcode  = r_ir[7:4];
   assign bus     = w_bus;
   assign a_out   = r_a;
   assign carry   = r_carry;
   assign halted  = r_halted;
   assign bus_err = r_bus_err;

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed bench for sap1_datapath.  Driver tasks apply one control word
// per cycle just after the rising edge.  Expected values are pushed into a
// queue, and a monitor on the falling edge pops them and compares them
// with the DUT outputs.
module tb_sap1_datapath;

  localparam logic [11:0] C_HLT = 12'h800;
  localparam logic [11:0] C_PCI = 12'h400;
  localparam logic [11:0] C_PCE = 12'h200;
  localparam logic [11:0] C_ML  = 12'h100;
  localparam logic [11:0] C_ME  = 12'h080;
  localparam logic [11:0] C_IL  = 12'h040;
  localparam logic [11:0] C_IE  = 12'h020;
  localparam logic [11:0] C_AL  = 12'h010;
  localparam logic [11:0] C_AE  = 12'h008;
  localparam logic [11:0] C_BL  = 12'h004;
  localparam logic [11:0] C_SUB = 12'h002;
  localparam logic [11:0] C_ADD = 12'h001;

  localparam int S_BUS = 0;
  localparam int S_A   = 1;
  localparam int S_CY  = 2;
  localparam int S_HLT = 3;
  localparam int S_ERR = 4;
  localparam int S_OP  = 5;

  typedef struct {
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] ctrl;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [7:0]  bus;
  logic [7:0]  a_out;
  logic        carry;
  logic        halted;
  logic        bus_err;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  sap1_datapath #(.RAM_INIT_ZERO(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl      (ctrl),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .opcode    (opcode),
    .bus       (bus),
    .a_out     (a_out),
    .carry     (carry),
    .halted    (halted),
    .bus_err   (bus_err)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  // Monitor: at each falling edge, compare every pending expectation
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        S_BUS:   act = bus;
        S_A:     act = a_out;
        S_CY:    act = {7'h00, carry};
        S_HLT:   act = {7'h00, halted};
        S_ERR:   act = {7'h00, bus_err};
        default: act = {4'h0, opcode};
      endcase
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %02h expected %02h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  task automatic chk(input int sel, input logic [7:0] v, input string nm);
    exp_t e;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [11:0] c, input logic we = 1'b0,
                      input logic [3:0] ad = 4'h0, input logic [7:0] d = 8'h00);
    @(posedge clk);
    #1;
    ctrl      = c;
    prog_we   = we;
    prog_addr = ad;
    prog_data = d;
  endtask

  // Load a register through ram[0] (mar is 0 in these sections)
  task automatic load_via_ram0(input logic [11:0] ld, input logic [7:0] v);
    step(12'h000, 1'b1, 4'h0, v);
    step(C_ME | ld);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(S_A,   8'h00, {tag, "_a"});
    chk(S_CY,  8'h00, {tag, "_carry"});
    chk(S_HLT, 8'h00, {tag, "_halted"});
    chk(S_ERR, 8'h00, {tag, "_bus_err"});
    chk(S_OP,  8'h00, {tag, "_opcode"});
    chk(S_BUS, 8'h00, {tag, "_bus"});
  endtask

  task automatic fetch();
    step(C_PCE | C_ML);
    step(C_PCI);
    step(C_ME | C_IL);
  endtask

  initial begin
    rst_n = 1'b0; ctrl = 12'h000; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // RAM read-during-write: old data this cycle, new data next cycle
    step(C_ME, 1'b1, 4'h0, 8'h09);
    chk(S_BUS, 8'h00, "rdw_old");
    step(C_ME);
    chk(S_BUS, 8'h09, "rdw_new");

    // PC wrap, and PC_EN with PC_INC in the same cycle
    repeat (15) step(C_PCI);
    step(C_PCE | C_PCI);
    chk(S_BUS, 8'h0F, "pc_f_on_bus");
    step(C_PCE);
    chk(S_BUS, 8'h00, "pc_wrap");

    // Adder: F0 + 20 = 10 with carry out
    load_via_ram0(C_AL, 8'hF0);
    load_via_ram0(C_BL, 8'h20);
    step(C_ADD | C_AL);
    chk(S_BUS, 8'h10, "add_bus");
    step(12'h000);
    chk(S_A,  8'h10, "add_a");
    chk(S_CY, 8'h01, "add_carry");
    // A load without the adder leaves carry alone
    load_via_ram0(C_AL, 8'h05);
    step(12'h000);
    chk(S_A,  8'h05, "lda_a");
    chk(S_CY, 8'h01, "carry_hold");
    // Subtract: 05 - 07 = FE, borrow (carry 0)
    load_via_ram0(C_BL, 8'h07);
    step(C_ADD | C_SUB | C_AL);
    chk(S_BUS, 8'hFE, "sub_bus");
    step(12'h000);
    chk(S_A,  8'hFE, "sub_a");
    chk(S_CY, 8'h00, "sub_carry");

    // Bus contention: A wins over MEM, and bus_err becomes sticky
    load_via_ram0(C_AL, 8'h33);
    step(12'h000, 1'b1, 4'h0, 8'h44);
    chk(S_ERR, 8'h00, "err_clear");
    step(C_AE | C_ME);
    chk(S_BUS, 8'h33, "contend_bus");
    step(12'h000);
    chk(S_ERR, 8'h01, "err_set");
    step(12'h000);
    chk(S_ERR, 8'h01, "err_sticky");
    step(12'h000);
    rst_n = 1'b0;
    chk_reset_outputs("rst1");
    step(12'h000);
    rst_n = 1'b1;

    // Program: LDA 9, ADD A, SUB B, HLT
    step(12'h000, 1'b1, 4'h0, 8'h09);
    step(12'h000, 1'b1, 4'h1, 8'h1A);
    step(12'h000, 1'b1, 4'h2, 8'h2B);
    step(12'h000, 1'b1, 4'h3, 8'hF0);
    step(12'h000, 1'b1, 4'h9, 8'h1C);
    step(12'h000, 1'b1, 4'hA, 8'h0E);
    step(12'h000, 1'b1, 4'hB, 8'h05);
    fetch();
    step(C_IE | C_ML);
    chk(S_OP, 8'h00, "lda_opcode");
    step(C_ME | C_AL);
    step(12'h000);
    chk(S_A, 8'h1C, "prog_lda");
    fetch();
    step(C_IE | C_ML);
    chk(S_OP, 8'h01, "add_opcode");
    step(C_ME | C_BL);
    step(C_ADD | C_AL);
    step(12'h000);
    chk(S_A,  8'h2A, "prog_add");
    chk(S_CY, 8'h00, "prog_add_carry");
    fetch();
    step(C_IE | C_ML);
    chk(S_OP, 8'h02, "sub_opcode");
    step(C_ME | C_BL);
    step(C_ADD | C_SUB | C_AL);
    step(12'h000);
    chk(S_A,  8'h25, "prog_sub");
    chk(S_CY, 8'h01, "prog_sub_carry");
    fetch();
    step(C_HLT);
    step(12'h000);
    chk(S_HLT, 8'h01, "halted");
    chk(S_OP,  8'h0F, "hlt_opcode");

    // Halted: registers are frozen, but RAM writes still happen
    step(C_ME | C_AL | C_PCI);
    step(C_PCE);
    chk(S_A,   8'h25, "halt_a_frozen");
    chk(S_BUS, 8'h04, "halt_pc_frozen");
    step(C_AE | C_ME);
    step(12'h000);
    chk(S_ERR, 8'h00, "halt_err_frozen");
    step(12'h000, 1'b1, 4'h3, 8'h77);
    step(C_ME);
    chk(S_BUS, 8'h77, "halt_ram_write");

    // Reset applied mid-cycle clears registers at once and keeps RAM
    step(12'h000);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (a_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rst2_async_a: got %02h expected 00 at %0t", a_out, $time);
    end
    n_tests++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL rst2_async_halted: got %0b expected 0 at %0t", halted, $time);
    end
    chk_reset_outputs("rst2");
    step(12'h000);
    rst_n = 1'b1;
    step(C_ME);
    chk(S_BUS, 8'h09, "ram_retained");
    step(C_PCE);
    chk(S_BUS, 8'h00, "pc_after_reset");

    step(12'h000);
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: %0d expectations left unchecked", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

endmodule
